// File: rtl/accum_cpu_pkg.sv
// Shared opcode constants and FSM state encoding for the accumulator processor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package accum_cpu_pkg;

    localparam int OPC_W = 3;

    localparam logic [OPC_W-1:0] OP_LOAD  = 3'b000;
    localparam logic [OPC_W-1:0] OP_STORE = 3'b001;
    localparam logic [OPC_W-1:0] OP_ADD   = 3'b010;
    localparam logic [OPC_W-1:0] OP_SUB   = 3'b011;
    localparam logic [OPC_W-1:0] OP_IN    = 3'b100;
    localparam logic [OPC_W-1:0] OP_JZ    = 3'b101;
    localparam logic [OPC_W-1:0] OP_JPOS  = 3'b110;
    localparam logic [OPC_W-1:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WAIT_IN,
        ST_HALT
    } state_t;

endpackage

// File: rtl/ram_sp_param.sv
// Single-port RAM holding program and data words; contents are never reset.
// Latency: 1-cycle synchronous read; write lands on the same edge.
// Backpressure: none, accepts one access every cycle (read returns old data on a write).
module ram_sp_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Synchronous write and registered read on the shared address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/accum_cpu.sv
// Accumulator processor: fetch/decode/execute sequencer around A and a program RAM.
// Latency: 3 cycles per instruction, IN adds >= 1 WAIT_IN cycle.
// Backpressure: in_ready only in WAIT_IN; program writes only accepted while IDLE or HALT.
module accum_cpu
    import accum_cpu_pkg::*;
#(
    parameter int DATA_W = 8,   // needs DATA_W >= ADDR_W + 3 so opcode and operand fit
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              aeq0,
    output logic              apos,
    output logic              halted,
    output logic              busy,
    output logic [ADDR_W-1:0] pc
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] ir_q;
    logic [ADDR_W-1:0] pc_q;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] operand;
    logic              ctrl_free;

    assign opcode    = ir_q[DATA_W-1 -: OPC_W];
    assign operand   = ir_q[ADDR_W-1:0];
    assign ctrl_free = (state_q == ST_IDLE) || (state_q == ST_HALT);

    ram_sp_param #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Next state plus RAM port steering: loader when free, PC in FETCH, operand otherwise.
    always_comb begin
        state_d   = state_q;
        ram_we    = 1'b0;
        ram_addr  = prog_addr;
        ram_wdata = prog_data;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                ram_we = prog_we;
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ram_addr = pc_q;
                state_d  = ST_DECODE;
            end
            ST_DECODE: begin
                // IR is loaded on this edge, so take the operand straight from the RAM output.
                ram_addr = ram_rdata[ADDR_W-1:0];
                state_d  = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                ram_addr  = operand;
                ram_wdata = acc_q;
                ram_we    = (opcode == OP_STORE);
                if (opcode == OP_IN) begin
                    state_d = ST_WAIT_IN;
                end else if (opcode == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WAIT_IN: begin
                if (in_valid) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Accumulator, PC and IR updates; jumps override the already-incremented PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        pc_q <= '0;
                    end
                end
                ST_FETCH:   pc_q <= pc_q + ADDR_W'(1);
                ST_DECODE:  ir_q <= ram_rdata;
                ST_EXECUTE: begin
                    case (opcode)
                        OP_LOAD: acc_q <= ram_rdata;
                        OP_ADD:  acc_q <= acc_q + ram_rdata;
                        OP_SUB:  acc_q <= acc_q - ram_rdata;
                        OP_JZ: begin
                            if (acc_q == '0) begin
                                pc_q <= operand;
                            end
                        end
                        OP_JPOS: begin
                            if (!acc_q[DATA_W-1]) begin
                                pc_q <= operand;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_WAIT_IN: begin
                    if (in_valid) begin
                        acc_q <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready = (state_q == ST_WAIT_IN);
    assign halted   = (state_q == ST_HALT);
    assign busy     = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                      (state_q == ST_EXECUTE) || (state_q == ST_WAIT_IN);
    assign out_data = acc_q;
    assign aeq0     = (acc_q == '0);
    assign apos     = ~acc_q[DATA_W-1];
    assign pc       = pc_q;

    logic unused_ok;
    assign unused_ok = ctrl_free;

endmodule

// File: tb/tb_accum_cpu.sv
module tb_accum_cpu;

    localparam int DW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [DW-1:0] prog_data = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, aeq0, apos, halted, busy;
    logic [DW-1:0] out_data;
    logic [AW-1:0] pc;

    int total = 0;
    int bad   = 0;
    int n;

    accum_cpu #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .aeq0      (aeq0),
        .apos      (apos),
        .halted    (halted),
        .busy      (busy),
        .pc        (pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: each instruction costs three cycles, results land
    // at the end of the third; IN then waits for a handshake.
    logic [DW-1:0] m_mem [0:(1<<AW)-1];
    logic [DW-1:0] m_a, m_ins, m_opnd;
    logic [AW-1:0] m_pc, m_cur;
    logic          m_busy, m_halted;
    int            m_ph;   // cycles spent in current instruction; 3 = waiting for input

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a = '0; m_pc = '0; m_cur = '0;
            m_busy = 1'b0; m_halted = 1'b0; m_ph = 0;
        end else if (!m_busy) begin
            if (prog_we) m_mem[prog_addr] = prog_data;
            if (start) begin
                m_busy = 1'b1; m_halted = 1'b0; m_pc = '0; m_ph = 0;
            end
        end else begin
            case (m_ph)
                0: begin m_cur = m_pc; m_pc = m_pc + 1; m_ph = 1; end
                1: m_ph = 2;
                2: begin
                    m_ins  = m_mem[m_cur];
                    m_opnd = m_mem[m_ins[AW-1:0]];
                    m_ph   = 0;
                    case (m_ins[DW-1:DW-3])
                        3'd0: m_a = m_opnd;
                        3'd1: m_mem[m_ins[AW-1:0]] = m_a;
                        3'd2: m_a = m_a + m_opnd;
                        3'd3: m_a = m_a - m_opnd;
                        3'd4: m_ph = 3;
                        3'd5: if (m_a == 0) m_pc = m_ins[AW-1:0];
                        3'd6: if (!m_a[DW-1]) m_pc = m_ins[AW-1:0];
                        default: begin m_busy = 1'b0; m_halted = 1'b1; end
                    endcase
                end
                default: if (in_valid) begin m_a = in_data; m_ph = 0; end
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("cycle", {14'd0, out_data, aeq0, apos, halted, busy, in_ready, pc},
              {14'd0, m_a, (m_a == 0), ~m_a[DW-1], m_halted, m_busy,
               (m_busy && m_ph == 3), m_pc});
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        prog_addr = a; prog_data = d; prog_we = 1'b1;
        cyc();
        prog_we = 1'b0;
    endtask

    task automatic run_halt(output int cnt);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cnt = 0;
        while (!halted && cnt < 400) begin cyc(); cnt++; end
    endtask

    initial begin
        #1;
        check("reset_a", out_data, 8'h00);
        check("reset_flags", {aeq0, apos, halted, busy, in_ready}, 5'b11000);
        check("reset_pc", pc, 5'd0);
        repeat (2) cyc();
        rst_n = 1'b1;

        // IN, ADD 10, HALT with input arriving after two WAIT_IN cycles.
        load(0, 8'h80); load(1, 8'h4A); load(2, 8'hE0); load(10, 8'h05);
        in_data = 8'h03;
        start = 1'b1; cyc(); start = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin cyc(); n++; end
        check("t1_wait_entry", n, 3);
        repeat (2) begin cyc(); n++; end
        check("t1_still_ready", in_ready, 1'b1);
        in_valid = 1'b1; cyc(); n++; in_valid = 1'b0;
        while (!halted && n < 50) begin cyc(); n++; end
        check("t1_cycles", n, 12);
        check("t1_a", out_data, 8'h08);
        check("t1_pc", pc, 5'd3);

        // Reset during WAIT_IN, then rerun the same program from RAM.
        start = 1'b1; cyc(); start = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin cyc(); n++; end
        cyc();
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_a", out_data, 8'h00);
        cyc();
        rst_n = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin cyc(); n++; end
        in_valid = 1'b1; cyc(); in_valid = 1'b0;
        n = 0;
        while (!halted && n < 50) begin cyc(); n++; end
        check("rerun_a", out_data, 8'h08);

        // 0 - 1 wraps to 0xFF.
        load(0, 8'h1F); load(31, 8'h00); load(1, 8'h7E); load(30, 8'h01); load(2, 8'hE0);
        run_halt(n);
        check("neg_a", out_data, 8'hFF);
        check("neg_flags", {aeq0, apos}, 2'b00);

        // Countdown loop: three iterations, 39 cycles.
        load(0, 8'h14); load(1, 8'h75); load(2, 8'h34); load(3, 8'hA5);
        load(4, 8'hC1); load(5, 8'hE0); load(20, 8'h03); load(21, 8'h01);
        run_halt(n);
        check("cd_cycles", n, 39);
        check("cd_a", out_data, 8'h00);
        check("cd_aeq0", aeq0, 1'b1);
        // Read back M[20] through a program: A = M[21] + M[20].
        load(0, 8'h15); load(1, 8'h54); load(2, 8'hE0);
        run_halt(n);
        check("cd_m20", out_data, 8'h01);

        // Program write while busy is dropped.
        load(0, 8'h0A); load(1, 8'h4A); load(2, 8'hE0); load(10, 8'h05);
        start = 1'b1; cyc(); start = 1'b0;
        prog_addr = 5'd2; prog_data = 8'h4A; prog_we = 1'b1;
        cyc();
        prog_we = 1'b0;
        n = 1;
        while (!halted && n < 100) begin cyc(); n++; end
        check("busy_we_cycles", n, 9);
        check("busy_we_a", out_data, 8'h0A);

        // Execution runs off M[31] and wraps to M[0].
        load(0, 8'h1D); load(1, 8'hA3); load(2, 8'hE0); load(3, 8'h1E);
        load(4, 8'h3D); load(5, 8'hDF); load(31, 8'h1C);
        load(28, 8'h07); load(29, 8'h00); load(30, 8'h01);
        run_halt(n);
        check("wrap_cycles", n, 27);
        check("wrap_a", out_data, 8'h01);
        check("wrap_pc", pc, 5'd3);

        repeat (2) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/accum_cpu.md
# accum_cpu

Parametrised accumulator processor: the single-register A/RAM add-subtract datapath plus its own instruction-sequencing FSM, so programs held in on-chip RAM run without an external controller. Data width and RAM depth are generic. It adds an input handshake, conditional branches, halt and a program-load port. It sits between the board I/O (switches/LEDs) and nothing else: it is a self-contained top-level compute block.

## Interface
- DATA_W, 8, accumulator, RAM word and instruction width; must satisfy DATA_W >= ADDR_W+3
- ADDR_W, 5, RAM address width; depth = 2^ADDR_W
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  begin execution at PC=0; honoured only in IDLE or HALT
- prog_we  in  1  program/data write strobe; honoured only in IDLE or HALT
- prog_addr  in  ADDR_W  write address
- prog_data  in  DATA_W  write data
- in_valid  in  1  input word available
- in_data  in  DATA_W  input word
- in_ready  out  1  high only in WAIT_IN
- out_data  out  DATA_W  accumulator A, continuously
- Aeq0  out  1  A == 0
- Apos  out  1  ~A[DATA_W-1]
- halted  out  1  high in HALT state
- busy  out  1  high in FETCH/DECODE/EXECUTE/WAIT_IN
- pc  out  ADDR_W  current program counter (debug)

## Operation
- Instruction word: opcode = bits [DATA_W-1:DATA_W-3], operand address a = bits [ADDR_W-1:0]; other bits ignored.
- Opcodes: 000 LOAD A<=M[a]; 001 STORE M[a]<=A; 010 ADD A<=A+M[a]; 011 SUB A<=A-M[a]; 100 IN A<=in_data via handshake; 101 JZ if A==0 PC<=a; 110 JPOS if A[MSB]==0 PC<=a (zero counts as positive); 111 HALT.
- Arithmetic modulo 2^DATA_W; no carry/overflow flags.
- States: IDLE, FETCH, DECODE, EXECUTE, WAIT_IN, HALT.
  - IDLE/HALT --Start--> FETCH with PC<=0; A is not cleared by Start.
  - FETCH: RAM read addr=PC; PC<=PC+1 (wraps 2^ADDR_W-1 -> 0).
  - DECODE: IR<=RAM output; RAM read addr=a.
  - EXECUTE: perform op using RAM output as M[a]; next FETCH, except IN -> WAIT_IN and HALT -> HALT.
  - WAIT_IN: in_ready=1; on in_valid, A<=in_data, next FETCH.
- STORE write occurs on the EXECUTE edge; self-modifying code is legal and visible to the next fetch.
- prog_we together with Start in the same IDLE cycle: the write completes; execution starts.
- prog_we in any busy state is ignored (no RAM write).
- Reset values: state IDLE, A=0, PC=0, IR=0, in_ready=0, halted=0, busy=0, Aeq0=1, Apos=1. RAM contents are not reset and survive Reset.

## Timing
- RAM: synchronous write and synchronous read, 1-cycle read latency.
- Non-IN instructions: exactly 3 cycles each (FETCH, DECODE, EXECUTE).
- IN: 3 cycles plus at least 1 WAIT_IN cycle. Transfer occurs on the edge where in_valid && in_ready. in_valid before WAIT_IN is not sampled.
- A, Aeq0, Apos update on the edge ending EXECUTE/WAIT_IN. Flags are combinational from A.
- Reset assertion mid-instruction: all outputs go to reset values immediately (asynchronous). A pending STORE is abandoned.
- halted rises on the edge leaving EXECUTE of HALT and stays high until Start or Reset.

## Structure
- Package accum_cpu_pkg: opcode constants (3-bit), state enum, OPC_W=3.
- One sub-module, ram_sp_param (DATA_W, ADDR_W): single-port, sync read/write. The core module muxes the RAM address between prog_addr, PC and a, and the write data between prog_data and A.
- Accumulator, PC, IR and FSM live in accum_cpu.

## Test plan
- Reset with no clocks -> A=0x00, Aeq0=1, Apos=1, halted=0, busy=0, in_ready=0.
- Load M[0]=0x80 (IN), M[1]=0x4A (ADD 10), M[2]=0xE0, M[10]=0x05; Start; drive in_data=0x03 with in_valid after 2 WAIT_IN cycles -> out_data=0x08, halted=1 after 12 cycles.
- Countdown: M[0]=0x14 (LOAD 20), M[1]=0x75 (SUB 21), M[2]=0x34 (STORE 20), M[3]=0xA5 (JZ 5), M[4]=0xC1 (JPOS 1), M[5]=0xE0, M[20]=3, M[21]=1 -> halts with A=0x00 and M[20]=0x00, 3 loop iterations.
- M[0]=0x01? no: M[0]=0x1F (LOAD 31) with M[31]=0x00, M[1]=0x7E (SUB 30), M[2]=0xE0, M[30]=0x01 -> A=0xFF, Apos=0, Aeq0=0.
- Reset asserted during WAIT_IN -> in_ready and busy drop immediately; after release, Start reruns the same program from RAM.
- prog_we to M[2] while busy -> ignored (program still halts). A straight-line program ending at M[31] wraps to fetch from M[0].
